// File: rtl/rx_iq_pkg.sv
// Shared types and default widths for the RX I/Q integrator.
package rx_iq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int RX_OW_DEFAULT = 16;
  localparam int CW_DEFAULT    = 16;

endpackage

// File: rtl/iq_accum_lane.sv
// One signed accumulator lane: sign-extends each enabled sample into an AW-bit sum.
// sum_next is the value the accumulator would hold after accepting din this cycle.
module iq_accum_lane #(
  parameter int IW = 16,
  parameter int AW = 32
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic [IW-1:0]        din,
  output logic signed [AW-1:0] sum_next
);

  logic signed [AW-1:0] acc;

  assign sum_next = acc + AW'($signed(din));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum_next;
    end
  end

endmodule

// File: rtl/rx_iq_integrator.sv
// Sums N decimated I/Q samples after a start pulse and holds the totals with busy/done status.
// Optional RX_IQ_INTEGRATOR_SHIFT_EN adds avg_shift for an arithmetic right shift of the final sums.
module rx_iq_integrator
  import rx_iq_pkg::*;
#(
  parameter int RX_OW = RX_OW_DEFAULT,
  parameter int CW    = CW_DEFAULT,
  parameter int AW    = RX_OW + CW
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 ce_in,
  input  logic [RX_OW-1:0]     in_x,
  input  logic [RX_OW-1:0]     in_y,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CW-1:0]        n_samples,
`ifdef RX_IQ_INTEGRATOR_SHIFT_EN
  input  logic [4:0]           avg_shift,
`endif
  output logic                 busy,
  output logic                 done,
  output logic signed [AW-1:0] result_x,
  output logic signed [AW-1:0] result_y,
  output logic [CW-1:0]        count
);

  state_t               state;
  logic [CW-1:0]        n_lat;
  logic                 go;
  logic                 take;
  logic                 last;
  logic signed [AW-1:0] sum_x;
  logic signed [AW-1:0] sum_y;
  logic signed [AW-1:0] fin_x;
  logic signed [AW-1:0] fin_y;

  // A strobe in the start cycle is never taken: the FSM is not yet in ACCUM.
  assign go   = start && !abort && (state != ACCUM);
  assign take = (state == ACCUM) && ce_in && !abort;
  assign last = take && ((count + 1'b1) == n_lat);

  iq_accum_lane #(.IW(RX_OW), .AW(AW)) u_lane_x (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .clear    (go),
    .en       (take),
    .din      (in_x),
    .sum_next (sum_x)
  );

  iq_accum_lane #(.IW(RX_OW), .AW(AW)) u_lane_y (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .clear    (go),
    .en       (take),
    .din      (in_y),
    .sum_next (sum_y)
  );

`ifdef RX_IQ_INTEGRATOR_SHIFT_EN
  logic [4:0] shift_lat;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      shift_lat <= '0;
    end else if (go) begin
      shift_lat <= avg_shift;
    end
  end

  assign fin_x = sum_x >>> shift_lat;
  assign fin_y = sum_y >>> shift_lat;
`else
  assign fin_x = sum_x;
  assign fin_y = sum_y;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result_x <= '0;
      result_y <= '0;
      count    <= '0;
      n_lat    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            n_lat <= n_samples;
            count <= '0;
            done  <= 1'b0;
            if (n_samples != '0) begin
              state <= ACCUM;
              busy  <= 1'b1;
            end else begin
              // Empty run: zero results, done follows one cycle later.
              state    <= DONE;
              result_x <= '0;
              result_y <= '0;
            end
          end else if (state == DONE) begin
            done <= 1'b1;
          end
        end
        ACCUM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (take) begin
            count <= count + 1'b1;
            if (last) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              result_x <= fin_x;
              result_y <= fin_y;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_iq_integrator.sv
// Self-checking bench for rx_iq_integrator: vector table, corner sequences, randomized runs vs. a sum model.
module tb_rx_iq_integrator;

  localparam int RX_OW = 16;
  localparam int CW    = 16;
  localparam int AW    = 32;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             ce_in;
  logic [RX_OW-1:0] in_x;
  logic [RX_OW-1:0] in_y;
  logic             start;
  logic             abort;
  logic [CW-1:0]    n_samples;
`ifdef RX_IQ_INTEGRATOR_SHIFT_EN
  logic [4:0]       avg_shift;
`endif
  logic             busy;
  logic             done;
  logic [AW-1:0]    result_x;
  logic [AW-1:0]    result_y;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;
  int sx [65536];
  int sy [65536];

  typedef struct {
    int     n;
    int     gap;
    int     x0, x1, x2, x3;
    int     y0, y1, y2, y3;
    longint ex;
    longint ey;
  } vec_t;

  always #5 sys_clk = ~sys_clk;

  rx_iq_integrator dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .ce_in     (ce_in),
    .in_x      (in_x),
    .in_y      (in_y),
    .start     (start),
    .abort     (abort),
    .n_samples (n_samples),
`ifdef RX_IQ_INTEGRATOR_SHIFT_EN
    .avg_shift (avg_shift),
`endif
    .busy      (busy),
    .done      (done),
    .result_x  (result_x),
    .result_y  (result_y),
    .count     (count)
  );

  function automatic longint rs(input logic [AW-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Start a run of n samples from sx/sy, one strobe every gap cycles, then check the outcome.
  task automatic run(input string nm, input int n, input int gap, input bit coinc,
                     input bit noise, input longint ex, input longint ey);
    bit bad;
    @(negedge sys_clk);
    start = 1'b1; n_samples = CW'(n); ce_in = coinc; in_x = 16'd100; in_y = 16'd100;
    @(negedge sys_clk);
    start = 1'b0; ce_in = 1'b0; bad = 1'b0;
    for (int k = 0; k < n; k++) begin
      for (int g = 1; g < gap; g++) begin
        if (!busy || done || count != CW'(k)) bad = 1'b1;
        if (noise) begin
          start = ($urandom_range(0, 3) == 0);
          n_samples = CW'($urandom);
        end
        @(negedge sys_clk);
      end
      if (!busy || done || count != CW'(k)) bad = 1'b1;
      ce_in = 1'b1; in_x = 16'(sx[k]); in_y = 16'(sy[k]);
      if (noise) begin
        start = ($urandom_range(0, 3) == 0);
        n_samples = CW'($urandom);
      end
      @(negedge sys_clk);
      ce_in = 1'b0; start = 1'b0;
      in_x = 16'($urandom); in_y = 16'($urandom);
    end
    chk({nm, " busy_span"}, longint'(bad), 0);
    chk({nm, " done"}, longint'(done), 1);
    chk({nm, " busy_end"}, longint'(busy), 0);
    chk({nm, " result_x"}, rs(result_x), ex);
    chk({nm, " result_y"}, rs(result_y), ey);
    chk({nm, " count"}, longint'(count), longint'(n));
  endtask

  initial begin
    vec_t   vt [4];
    longint ax, ay;
    int     n, gap, sh;

    vt[0] = '{1, 1, -1, 0, 0, 0, 32767, 0, 0, 0, -1, 32767};
    vt[1] = '{3, 2, 32767, 32767, 32767, 0, -32768, -32768, -32768, 0, 98301, -98304};
    vt[2] = '{2, 3, -20000, 5, 0, 0, 3, -4, 0, 0, -19995, -1};
    vt[3] = '{4, 5, 100, -50, 7, -1, -32768, -32768, -32768, -32768, 56, -131072};

    rst = 1'b1; ce_in = 1'b0; start = 1'b0; abort = 1'b0;
    in_x = '0; in_y = '0; n_samples = '0;
`ifdef RX_IQ_INTEGRATOR_SHIFT_EN
    avg_shift = '0;
`endif
    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    @(negedge sys_clk);
    chk("reset busy", longint'(busy), 0);
    chk("reset done", longint'(done), 0);
    chk("reset result_x", rs(result_x), 0);
    chk("reset result_y", rs(result_y), 0);
    chk("reset count", longint'(count), 0);

    foreach (vt[i]) begin
      sx[0] = vt[i].x0; sx[1] = vt[i].x1; sx[2] = vt[i].x2; sx[3] = vt[i].x3;
      sy[0] = vt[i].y0; sy[1] = vt[i].y1; sy[2] = vt[i].y2; sy[3] = vt[i].y3;
      run($sformatf("vec%0d", i), vt[i].n, vt[i].gap, 1'b0, 1'b0, vt[i].ex, vt[i].ey);
    end

    // Abort while in DONE clears done but keeps results.
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    chk("abort_done done", longint'(done), 0);
    chk("abort_done result_x", rs(result_x), 56);

    // Abort after 2 of 5 samples, then start+abort together.
    start = 1'b1; n_samples = 16'd5;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (2) begin
      ce_in = 1'b1; in_x = 16'd9; in_y = 16'd9;
      @(negedge sys_clk);
      ce_in = 1'b0;
    end
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    chk("abort busy", longint'(busy), 0);
    chk("abort done", longint'(done), 0);
    chk("abort result_x", rs(result_x), 56);
    chk("abort count", longint'(count), 2);
    start = 1'b1; abort = 1'b1; n_samples = 16'd3;
    @(negedge sys_clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort busy", longint'(busy), 0);
    chk("start_abort count", longint'(count), 2);
    @(negedge sys_clk);
    chk("start_abort idle", longint'(busy | done), 0);

    // Asynchronous reset in the middle of a run.
    start = 1'b1; n_samples = 16'd10;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (3) begin
      ce_in = 1'b1; in_x = 16'd1; in_y = 16'd1;
      @(negedge sys_clk);
      ce_in = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("midreset busy", longint'(busy), 0);
    chk("midreset done", longint'(done), 0);
    chk("midreset result_x", rs(result_x), 0);
    chk("midreset result_y", rs(result_y), 0);
    chk("midreset count", longint'(count), 0);
    @(negedge sys_clk);
    rst = 1'b0;
    sx[0] = 7; sx[1] = -9; sy[0] = 1; sy[1] = 2;
    run("after_reset", 2, 1, 1'b0, 1'b0, -2, 3);

    // N=0: done two cycles after start, zero results, never busy.
    @(negedge sys_clk);
    start = 1'b1; n_samples = '0;
    @(negedge sys_clk);
    start = 1'b0;
    chk("n0 done_early", longint'(done), 0);
    chk("n0 busy_early", longint'(busy), 0);
    @(negedge sys_clk);
    chk("n0 done", longint'(done), 1);
    chk("n0 busy", longint'(busy), 0);
    chk("n0 result_x", rs(result_x), 0);
    chk("n0 result_y", rs(result_y), 0);
    chk("n0 count", longint'(count), 0);

    sx[0] = 5; sx[1] = 6; sy[0] = -1; sy[1] = -1;
    run("coincident", 2, 1, 1'b1, 1'b0, 11, -2);

`ifdef RX_IQ_INTEGRATOR_SHIFT_EN
    for (int k = 0; k < 8; k++) begin
      sx[k] = -3; sy[k] = 5;
    end
    avg_shift = 5'd3;
    run("shift", 8, 1, 1'b0, 1'b0, -3, 5);
    avg_shift = '0;
`endif

    // Randomized runs against a plain-sum reference model.
    for (int r = 0; r < 15; r++) begin
      n = $urandom_range(1, 40);
      gap = $urandom_range(1, 3);
      sh = 0;
`ifdef RX_IQ_INTEGRATOR_SHIFT_EN
      sh = $urandom_range(0, 6);
      avg_shift = 5'(sh);
`endif
      ax = 0; ay = 0;
      for (int k = 0; k < n; k++) begin
        sx[k] = int'($urandom_range(0, 65535)) - 32768;
        sy[k] = int'($urandom_range(0, 65535)) - 32768;
        ax += longint'(sx[k]);
        ay += longint'(sy[k]);
      end
      run($sformatf("rand%0d", r), n, gap, r[0], 1'b1, ax >>> sh, ay >>> sh);
    end
`ifdef RX_IQ_INTEGRATOR_SHIFT_EN
    avg_shift = '0;
`endif

    // Full-scale run: largest N with extreme constant samples.
    for (int k = 0; k < 65535; k++) begin
      sx[k] = 32767; sy[k] = -32768;
    end
    run("full_scale", 65535, 1, 1'b0, 1'b0, 2147385345, -2147450880);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
